// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;
  localparam int REG_W       = 5;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use compare: the load in ID/EX writes a register the IF/ID instruction reads.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  output logic             load_use_o
);
  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use_o = idex_memread_i && (idex_rd_i != '0) &&
                      ((idex_rd_i == ifid_rs_i) || (idex_rd_i == ifid_rt_i));
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: FSM for data-memory waits with watchdog, load-use
// stall, branch flush decode and a saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             branch_taken_i,
  input  logic             exmem_access_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             memwb_bubble_o,
  output logic             dmem_req_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic load_use;
  logic hold;
  logic pc_w, ifid_w, ifid_fl, idex_w, idex_b, exmem_w, memwb_b, req;

  hazard_detect u_hazard (
    .idex_memread_i (idex_memread_i),
    .idex_rd_i      (idex_rd_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .load_use_o     (load_use)
  );

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    hold    = 1'b0;
    req     = 1'b0;
    unique case (state_q)
      RUN: begin
        req  = exmem_access_i;
        wd_d = '0;
        if (exmem_access_i && !dmem_ack_i) begin
          hold    = 1'b1;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        req = 1'b1;
        if (dmem_ack_i) begin
          state_d = RUN;
          wd_d    = '0;
        end else begin
          hold = 1'b1;
          if (wd_q == WD_W'(TIMEOUT - 1)) state_d = ERROR;
          else                            wd_d    = wd_q + 1'b1;
        end
      end
      ERROR: begin
        hold = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Output decode in priority order: full hold, load-use, branch flush.
  always_comb begin
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_fl = 1'b0;
    idex_w  = 1'b1;
    idex_b  = 1'b0;
    exmem_w = 1'b1;
    memwb_b = 1'b0;
    if (hold) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_w = 1'b0;
      memwb_b = 1'b1;
    end else if (load_use) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      idex_b = 1'b1;
    end else begin
      ifid_fl = branch_taken_i;
    end
  end

  // Reset gates every control output so a pending access is aborted immediately.
  assign pc_write_o     = rst_n_i & pc_w;
  assign ifid_write_o   = rst_n_i & ifid_w;
  assign ifid_flush_o   = rst_n_i & ifid_fl;
  assign idex_write_o   = rst_n_i & idex_w;
  assign idex_bubble_o  = rst_n_i & idex_b;
  assign exmem_write_o  = rst_n_i & exmem_w;
  assign memwb_bubble_o = rst_n_i & memwb_b;
  assign dmem_req_o     = rst_n_i & req;
  assign err_o          = err_q;
  assign stall_cnt_o    = cnt_q;

  always_comb begin
    err_d = err_q | (state_d == ERROR);
    cnt_d = cnt_q;
    if (!pc_write_o && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl (TIMEOUT=8, CNT_W=4).
module tb_pipeline_ctrl;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  // Expected output vector: {pc, ifid_w, ifid_flush, idex_w, idex_bubble,
  //                          exmem_w, memwb_bubble, dmem_req, err}
  localparam logic [8:0] E_RST    = 9'b000000000;
  localparam logic [8:0] E_RUN    = 9'b110101000;
  localparam logic [8:0] E_RUNREQ = 9'b110101010;
  localparam logic [8:0] E_FL     = 9'b111101000;
  localparam logic [8:0] E_LU     = 9'b000111000;
  localparam logic [8:0] E_LUREQ  = 9'b000111010;
  localparam logic [8:0] E_HOLD   = 9'b000000110;
  localparam logic [8:0] E_ERR    = 9'b000000101;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             idex_memread_i = 1'b0;
  logic [4:0]       idex_rd_i = '0;
  logic [4:0]       ifid_rs_i = '0;
  logic [4:0]       ifid_rt_i = '0;
  logic             branch_taken_i = 1'b0;
  logic             exmem_access_i = 1'b0;
  logic             dmem_ack_i = 1'b0;
  logic             pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o;
  logic             idex_bubble_o, exmem_write_o, memwb_bubble_o, dmem_req_o, err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  always #5 clk_i = ~clk_i;

  pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .idex_memread_i (idex_memread_i),
    .idex_rd_i      (idex_rd_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .branch_taken_i (branch_taken_i),
    .exmem_access_i (exmem_access_i),
    .dmem_ack_i     (dmem_ack_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_write_o   (idex_write_o),
    .idex_bubble_o  (idex_bubble_o),
    .exmem_write_o  (exmem_write_o),
    .memwb_bubble_o (memwb_bubble_o),
    .dmem_req_o     (dmem_req_o),
    .err_o          (err_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  logic [12:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  // One call = one clock cycle of stimulus plus its expected response.
  task automatic drive(input logic rst, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic br,
                       input logic acc, input logic ack, input logic [8:0] eo,
                       input logic [3:0] ec, input string nm);
    @(posedge clk_i);
    #1;
    rst_n_i        = rst;
    idex_memread_i = mr;
    idex_rd_i      = rd;
    ifid_rs_i      = rs;
    ifid_rt_i      = rt;
    branch_taken_i = br;
    exmem_access_i = acc;
    dmem_ack_i     = ack;
    exp_q.push_back({eo, ec});
    name_q.push_back(nm);
  endtask

  logic [12:0] mon_exp, mon_got;
  string       mon_name;

  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_got  = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o,
                  exmem_write_o, memwb_bubble_o, dmem_req_o, err_o, stall_cnt_o};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL %s: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d", mon_name,
                 mon_got[12:4], mon_got[3:0], mon_exp[12:4], mon_exp[3:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not complete within time limit");
    $fatal(1);
  end

  initial begin
    drive(0, 1, 5, 5, 0, 1, 1, 0, E_RST, 4'd0, "reset_hold");
    drive(0, 0, 0, 0, 0, 0, 0, 0, E_RST, 4'd0, "reset_idle");
    drive(1, 1, 5, 5, 0, 0, 0, 0, E_LU,  4'd0, "lu_rs_stall");
    drive(1, 0, 0, 5, 0, 0, 0, 0, E_RUN, 4'd1, "lu_release");
    drive(1, 1, 0, 0, 0, 0, 0, 0, E_RUN, 4'd1, "zero_reg_guard");
    drive(1, 1, 7, 3, 7, 0, 0, 0, E_LU,  4'd1, "lu_rt_stall");
    drive(1, 0, 0, 0, 0, 0, 0, 0, E_RUN, 4'd2, "lu_rt_release");
    drive(1, 1, 7, 8, 9, 0, 0, 0, E_RUN, 4'd2, "lu_no_match");
    drive(1, 0, 0, 0, 0, 1, 0, 0, E_FL,  4'd2, "branch_flush");
    drive(1, 0, 0, 0, 0, 0, 1, 0, E_HOLD,   4'd2, "mem_req");
    drive(1, 0, 0, 0, 0, 0, 1, 0, E_HOLD,   4'd3, "mem_wait1");
    drive(1, 0, 0, 0, 0, 0, 1, 0, E_HOLD,   4'd4, "mem_wait2");
    drive(1, 0, 0, 0, 0, 0, 1, 1, E_RUNREQ, 4'd5, "mem_ack");
    drive(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,    4'd5, "mem_done");
    drive(1, 0, 0, 0, 0, 0, 1, 1, E_RUNREQ, 4'd5, "ack_first_cycle");
    drive(1, 0, 0, 0, 0, 0, 0, 1, E_RUN,    4'd5, "ack_without_req");
    drive(1, 0, 0, 0, 0, 0, 1, 0, E_HOLD,   4'd5, "pri_req");
    drive(1, 1, 5, 5, 0, 1, 1, 0, E_HOLD,   4'd6, "pri_hold");
    drive(1, 1, 5, 5, 0, 1, 1, 1, E_LUREQ,  4'd7, "pri_ack_lu");
    drive(1, 0, 0, 5, 0, 1, 0, 0, E_FL,     4'd8, "pri_flush");
    drive(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,    4'd8, "pri_done");
    drive(0, 0, 0, 0, 0, 0, 0, 0, E_RST,    4'd0, "to_reset");
    drive(1, 0, 0, 0, 0, 0, 1, 0, E_HOLD,   4'd0, "to_req");
    for (int i = 0; i < TIMEOUT; i++)
      drive(1, 0, 0, 0, 0, 0, 1, 0, E_HOLD, 4'(i + 1), "to_wait");
    drive(1, 0, 0, 0, 0, 0, 1, 0, E_ERR,    4'd9,  "to_error");
    drive(1, 1, 5, 5, 0, 1, 1, 1, E_ERR,    4'd10, "to_error_sticky");
    drive(0, 0, 0, 0, 0, 0, 0, 0, E_RST,    4'd0,  "to_clear");
    drive(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,    4'd0,  "to_run");
    for (int i = 0; i < 20; i++)
      drive(1, 1, 5, 5, 0, 0, 0, 0, E_LU, 4'((i < 15) ? i : 15), "sat_stall");
    drive(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,    4'd15, "sat_hold");
    drive(0, 0, 0, 0, 0, 0, 0, 0, E_RST,    4'd0,  "rw_reset");
    drive(1, 0, 0, 0, 0, 0, 1, 0, E_HOLD,   4'd0,  "rw_req");
    drive(1, 0, 0, 0, 0, 0, 1, 0, E_HOLD,   4'd1,  "rw_wait");
    drive(0, 0, 0, 0, 0, 0, 1, 0, E_RST,    4'd0,  "rw_abort");
    drive(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,    4'd0,  "rw_run");
    @(negedge clk_i);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It handles:
- load-use hazards,
- taken-branch flushes,
- multi-cycle data-memory accesses, using a request/ack handshake with a watchdog.

It sits beside the pipeline registers and drives their write-enable and bubble inputs; it holds no datapath state of its own.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles spent in MEM_WAIT before the error trap.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- idex_memread_i  in  1  the instruction in ID/EX is a load.
- idex_rd_i  in  5  destination register of the instruction in ID/EX.
- ifid_rs_i, ifid_rt_i  in  5 each  source registers of the instruction in IF/ID.
- branch_taken_i  in  1  a branch resolved taken in ID this cycle.
- exmem_access_i  in  1  the instruction in EX/MEM reads or writes data memory.
- dmem_ack_i  in  1  data memory has completed the current access.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  clears IF/ID to a NOP.
- idex_write_o  out  1  ID/EX load enable.
- idex_bubble_o  out  1  loads zero control bits into ID/EX.
- exmem_write_o  out  1  EX/MEM load enable.
- memwb_bubble_o  out  1  forces MEM/WB regwrite and memtoreg to 0.
- dmem_req_o  out  1  data memory request.
- err_o  out  1  sticky memory-timeout error.
- stall_cnt_o  out  CNT_W  saturating count of cycles in which pc_write_o was 0.

## Operation
States (package enum): RUN, MEM_WAIT, ERROR. Reset state is RUN.

RUN:
- dmem_req_o = exmem_access_i.
- **Memory stall**: exmem_access_i=1 and dmem_ack_i=0.
  - Go to MEM_WAIT.
  - In this cycle, drive pc_write, ifid_write, idex_write and exmem_write to 0, and memwb_bubble to 1.
- **Load-use hazard**, applied only when there is no memory stall: idex_memread_i=1, idex_rd_i≠0, and idex_rd_i equals ifid_rs_i or ifid_rt_i.
  - pc_write=0, ifid_write=0, idex_bubble=1.
  - exmem_write=1, idex_write=1.
- **Branch flush**, applied only when there is no memory stall and no load-use hazard: branch_taken_i=1 gives ifid_flush=1, with all write enables at 1.
- **Otherwise**: all write enables 1; flush and bubble outputs 0.

MEM_WAIT:
- dmem_req_o=1.
- Watchdog increments every cycle spent in MEM_WAIT.
- dmem_ack_i=1:
  - Return to RUN.
  - Same-cycle outputs are the RUN outputs with the memory-stall term masked, so the pipeline advances in the ack cycle.
  - Watchdog clears.
- No ack:
  - Keep the full hold (pc_write, ifid_write, idex_write and exmem_write at 0; memwb_bubble at 1).
  - Load-use and branch terms are ignored.
- Watchdog reaches TIMEOUT-1 without ack: go to ERROR.

ERROR:
- Full hold, dmem_req_o=0, err_o=1.
- Remains in ERROR until reset.

Priority: ERROR > memory stall > load-use > branch flush.

Stall counter:
- Increments on every cycle in which pc_write_o=0.
- Saturates at all-ones; it does not wrap.

## Timing
- All control outputs are combinational from the current state and inputs, with zero latency.
- err_o, stall_cnt_o, the state register and the watchdog are registered on the rising edge of clk_i.
- While rst_n_i=0:
  - state=RUN, watchdog=0, err_o=0, stall_cnt_o=0.
  - All *_write_o, flush and bubble outputs and dmem_req_o are forced to 0.
- Reset asserted mid-MEM_WAIT aborts the access: dmem_req_o drops asynchronously.
- Ack timing:
  - An ack in the first request cycle of an access costs 0 stall cycles.
  - An ack after N wait cycles costs exactly N stall cycles.
- Load-use stall lasts exactly 1 cycle. In the next cycle ID/EX holds the bubble, so the hazard compare is false.
- dmem_ack_i while dmem_req_o=0 is ignored.
- A branch that arrives during a stall is re-presented by the held IF/ID; no flush is lost.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, ERROR);
  - the REG_W=5 constant;
  - the default TIMEOUT and CNT_W values.
- Sub-module hazard_detect: combinational load-use compare producing a single load_use flag.
- The top level holds the FSM, the watchdog, the stall counter and the output decode.

## Test plan
- **Load-use**: idex_memread=1, idex_rd=5, ifid_rs=5 → one cycle with pc_write=0, ifid_write=0, idex_bubble=1; the next cycle is all enables 1; stall_cnt_o=1.
- **Zero-register guard**: idex_rd=0, ifid_rs=0, idex_memread=1 → no stall.
- **Memory wait**: exmem_access=1, ack arrives 3 cycles after the request → 3 full-hold cycles with memwb_bubble=1; the pipeline advances in the ack cycle; stall_cnt_o=3.
- **Priority**: a load-use hazard and branch_taken arrive during MEM_WAIT → only the full hold is visible; after the ack the load-use stall is applied first, and the flush follows once the stall clears.
- **Timeout**: TIMEOUT=8, no ack → after 8 wait cycles err_o=1, dmem_req_o=0, and the hold persists; rst_n_i pulse low → err_o=0 and state RUN.
- **Counter saturation**: CNT_W=4, 20 forced stall cycles → stall_cnt_o holds at 15.
